seq_checker: RTL

- Receive-side counterpart of the switch-loaded up/down sequence generator (`fsm`) that drives the LEDs.
- Samples a 4-bit sequence stream on each clock-enable strobe and auto-detects the counting direction.
- Declares lock after a run of consecutive correct steps, then flags every broken step.
- Sits downstream of the generator, or of any source strobed by the button-filter CE, for self-test and loopback checking.

---
 rtl/seq_checker.sv | 97 +++++++++
 1 files changed

// File: rtl/seq_checker.sv
// Receive-side sequence checker: acquires the counting direction of a strobed
// up/down stream, locks after LOCK_CNT good steps and flags broken steps.
//
// state  | meaning
// IDLE   | no reference sample yet; the next ce sample becomes the reference
// DETECT | reference held, waiting for a +1 or -1 step to pick the direction
// TRACK  | direction known, counting consecutive good steps toward lock
// LOCKED | stream tracked; any broken step pulses err and re-acquires
module seq_checker #(
  parameter int DW       = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             load,
  input  logic [DW-1:0]    seq,
  output logic             locked,
  output logic             dir,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [DW-1:0]    last
);

  typedef enum logic [1:0] {IDLE, DETECT, TRACK, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  state_t        state;
  logic [3:0]    match;
  logic [DW-1:0] up_val, dn_val, exp_val;

  assign up_val  = last + DW'(1);
  assign dn_val  = last - DW'(1);
  assign exp_val = dir ? up_val : dn_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= '0;
      dir     <= 1'b1;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      match   <= '0;
    end else begin
      err <= 1'b0;
      if (load) begin
        state  <= IDLE;
        locked <= 1'b0;
        match  <= '0;
      end else if (ce) begin
        last <= seq;
        case (state)
          IDLE: state <= DETECT;
          DETECT: begin
            // up is tested first so it wins when both steps coincide (DW=1)
            if (seq == up_val || seq == dn_val) begin
              dir   <= (seq == up_val);
              match <= 4'd1;
              if (LOCK_N <= 4'd1) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                state <= TRACK;
              end
            end
          end
          TRACK: begin
            if (seq == exp_val) begin
              match <= match + 4'd1;
              if (match + 4'd1 >= LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              state <= DETECT;
              match <= '0;
            end
          end
          LOCKED: begin
            if (seq != exp_val) begin
              err    <= 1'b1;
              locked <= 1'b0;
              match  <= '0;
              state  <= DETECT;
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
